// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Iterative shift-add multiplier: one (WIDTH+1)-bit adder, one iteration per
//   multiplier bit, start/done/ack handshake. Unsigned or two's-complement
//   operands selected per operation via signed_i.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start_i, signed_i    request and operand mode, sampled in IDLE only
//   a_i, b_i             multiplicand / multiplier, sampled with start_i
//   ack_i                consumer took product_o, sampled in DONE only
//   busy_o               high in RUN and DONE
//   done_o               high in DONE, product_o valid
//   product_o            2*WIDTH-bit result, held until the next DONE entry
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    m, m_next;
  logic [WIDTH-1:0]    q, q_next;
  logic [WIDTH-1:0]    acc, acc_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                neg, neg_next;
  logic [PROD_W-1:0]   product_next;

  logic [WIDTH:0]      addend;
  logic [WIDTH:0]      sum;
  logic [PROD_W-1:0]   shifted;

  // Single adder; the carry bit is shifted into ACC's MSB
  always_comb begin
    addend  = q[0] ? {1'b0, m} : '0;
    sum     = {1'b0, acc} + addend;
    shifted = {sum, q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_next   = state;
    m_next       = m;
    q_next       = q;
    acc_next     = acc;
    cnt_next     = cnt;
    neg_next     = neg;
    product_next = product_o;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          // Magnitudes in WIDTH bits; |-2^(WIDTH-1)| still fits unsigned
          m_next     = (signed_i && a_i[WIDTH-1]) ? WIDTH'(-a_i) : a_i;
          q_next     = (signed_i && b_i[WIDTH-1]) ? WIDTH'(-b_i) : b_i;
          acc_next   = '0;
          cnt_next   = '0;
          neg_next   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        acc_next = shifted[PROD_W-1:WIDTH];
        q_next   = shifted[WIDTH-1:0];
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          // Negating a zero magnitude yields zero, so no -0 artefact
          product_next = neg ? PROD_W'(-shifted) : shifted;
          state_next   = S_DONE;
        end
      end
      S_DONE: begin
        if (ack_i) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      m         <= m_next;
      q         <= q_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      neg       <= neg_next;
      product_o <= product_next;
      busy_o    <= (state_next != S_IDLE);
      done_o    <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier
//   Directed WIDTH=8 checks plus 1000 random WIDTH=16 operations, compared
//   against an arithmetic reference product and the expected handshake timing.
module tb_seq_shift_add_multiplier;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start8, sg8, ack8, busy8, done8;
  logic [W8-1:0]    a8, b8;
  logic [2*W8-1:0]  product8;

  logic             start16, sg16, ack16, busy16, done16;
  logic [W16-1:0]   a16, b16;
  logic [2*W16-1:0] product16;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_add_multiplier #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .signed_i(sg8), .a_i(a8), .b_i(b8),
    .ack_i(ack8), .busy_o(busy8), .done_o(done8), .product_o(product8)
  );

  seq_shift_add_multiplier #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .signed_i(sg16), .a_i(a16), .b_i(b16),
    .ack_i(ack16), .busy_o(busy16), .done_o(done16), .product_o(product16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: interpret operands, multiply, truncate to 2*w bits
  function automatic logic [63:0] ref_mul(input int unsigned w, input bit s,
                                          input longint unsigned a, input longint unsigned b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Present a request for one edge, then scramble the operand inputs
  task automatic start_op8(input bit s, input logic [W8-1:0] a, input logic [W8-1:0] b);
    @(negedge clk);
    start8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom); sg8 = 1'($urandom);
  endtask

  // Called right after the accepting edge; counts edges until done_o
  task automatic wait_done8(input string tag, output int edges);
    edges = 1;
    while (!done8 && edges < 40) begin
      check({tag, "_busy"}, 64'(busy8), 64'd1);
      @(negedge clk);
      edges++;
    end
    check({tag, "_done"}, 64'(done8), 64'd1);
  endtask

  task automatic op8(input string tag, input bit s, input logic [W8-1:0] a, input logic [W8-1:0] b);
    int edges;
    logic [63:0] exp;
    exp = ref_mul(W8, s, a, b);
    start_op8(s, a, b);
    wait_done8(tag, edges);
    check({tag, "_lat"}, 64'(edges), 64'(W8 + 1));
    check({tag, "_prod"}, 64'(product8), exp);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    check({tag, "_idle"}, 64'({busy8, done8}), 64'd0);
    check({tag, "_keep"}, 64'(product8), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    bit s;
    logic [W16-1:0] ra, rb;
    logic [63:0] exp;

    rst = 1'b1;
    start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0; ack8 = 1'b0;
    start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0; ack16 = 1'b0;

    // Reset state
    #12;
    check("rst8_busy", 64'(busy8), 64'd0);
    check("rst8_done", 64'(done8), 64'd0);
    check("rst8_prod", 64'(product8), 64'd0);
    check("rst16_out", 64'({busy16, done16, product16}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products
    op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF);
    check("u_ff_ff_lit", 64'(product8), 64'h0000_FE01);
    op8("s_m128_m128", 1'b1, 8'h80, 8'h80);
    check("s_m128_lit", 64'(product8), 64'h0000_4000);
    op8("s_m3_5", 1'b1, 8'hFD, 8'h05);
    check("s_m3_5_lit", 64'(product8), 64'h0000_FFF1);
    op8("s_0_m7", 1'b1, 8'h00, 8'hF9);
    check("s_0_m7_lit", 64'(product8), 64'h0000_0000);
    op8("u_80_80", 1'b0, 8'h80, 8'h80);
    op8("s_m1_m1", 1'b1, 8'hFF, 8'hFF);

    // start_i during RUN and DONE is ignored; ack held off for 20 cycles
    start_op8(1'b0, 8'd7, 8'd9);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("ign_run", edges);
    check("ign_run_prod", 64'(product8), 64'd63);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_done", 64'(done8), 64'd1);
      check("hold_prod", 64'(product8), 64'd63);
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0; start8 = 1'b0;
    check("ack_start_idle", 64'({busy8, done8}), 64'd0);
    check("ack_keep", 64'(product8), 64'd63);
    @(negedge clk);
    check("ack_start_noq", 64'(busy8), 64'd0);

    // Async reset at RUN iteration 4 aborts the operation
    start_op8(1'b0, 8'h55, 8'h33);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_prod", 64'(product8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_nodone", 64'({busy8, done8}), 64'd0);
    op8("post_rst", 1'b0, 8'd12, 8'd10);
    check("post_rst_lit", 64'(product8), 64'h0000_0078);

    // WIDTH=16 random operations
    for (int i = 0; i < 1000; i++) begin
      s  = 1'($urandom);
      ra = W16'($urandom);
      rb = W16'($urandom);
      if (i % 50 == 0) ra = 16'h8000;
      if (i % 70 == 1) rb = 16'h0000;
      exp = ref_mul(W16, s, ra, rb);
      @(negedge clk);
      start16 = 1'b1; sg16 = s; a16 = ra; b16 = rb;
      @(negedge clk);
      start16 = 1'b0; a16 = W16'($urandom); b16 = W16'($urandom);
      edges = 1;
      while (!done16 && edges < 60) begin
        @(negedge clk);
        edges++;
      end
      check("r16_lat", 64'(edges), 64'(W16 + 1));
      check("r16_prod", 64'(product16), exp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ack16 = 1'b1;
      @(negedge clk);
      ack16 = 1'b0;
    end
    @(negedge clk);
    check("r16_idle", 64'({busy16, done16}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
